// File: rtl/cxu_l2_req_fifo.sv
// CXU-L2 request queue: buffers requests toward a subordinate CXU, caps outstanding
// requests at MAX_INFLIGHT and passes in-order responses straight back upstream.
module cxu_l2_req_fifo #(
  parameter int unsigned CXU_N_CXUS    = 1,
  parameter int unsigned CXU_N_STATES  = 0,
  parameter int unsigned CXU_FUNC_ID_W = 0,
  parameter int unsigned CXU_INSN_W    = 0,
  parameter int unsigned CXU_DATA_W    = 32,
  parameter int unsigned CXU_STATUS_W  = 3,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned MAX_INFLIGHT  = 2,
  localparam int unsigned CXU_ID_W   = (CXU_N_CXUS > 1) ? $clog2(CXU_N_CXUS) : 1,
  localparam int unsigned STATE_ID_W = (CXU_N_STATES > 1) ? $clog2(CXU_N_STATES) : 1,
  localparam int unsigned FUNC_W     = (CXU_FUNC_ID_W > 0) ? CXU_FUNC_ID_W : 1,
  localparam int unsigned INSN_W     = (CXU_INSN_W > 0) ? CXU_INSN_W : 1,
  localparam int unsigned PTR_W      = $clog2(DEPTH),
  localparam int unsigned LVL_W      = PTR_W + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clk_en,
  // Upstream request
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [CXU_ID_W-1:0]     req_cxu,
  input  logic [STATE_ID_W-1:0]   req_state,
  input  logic [FUNC_W-1:0]       req_func,
  input  logic [INSN_W-1:0]       req_insn,
  input  logic [CXU_DATA_W-1:0]   req_data0,
  input  logic [CXU_DATA_W-1:0]   req_data1,
  // Upstream response
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [CXU_STATUS_W-1:0] resp_status,
  output logic [CXU_DATA_W-1:0]   resp_data,
  // Downstream request
  output logic                    t_req_valid,
  input  logic                    t_req_ready,
  output logic [CXU_ID_W-1:0]     t_req_cxu,
  output logic [STATE_ID_W-1:0]   t_req_state,
  output logic [FUNC_W-1:0]       t_req_func,
  output logic [INSN_W-1:0]       t_req_insn,
  output logic [CXU_DATA_W-1:0]   t_req_data0,
  output logic [CXU_DATA_W-1:0]   t_req_data1,
  // Downstream response
  input  logic                    t_resp_valid,
  output logic                    t_resp_ready,
  input  logic [CXU_STATUS_W-1:0] t_resp_status,
  input  logic [CXU_DATA_W-1:0]   t_resp_data,
  // Status
  output logic [LVL_W-1:0]        level,
  output logic [3:0]              inflight
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 2");
  end
  if (MAX_INFLIGHT < 1 || MAX_INFLIGHT > 15) begin : g_bad_inflight
    $error("MAX_INFLIGHT must be in 1..15");
  end

  // Storage is not reset; only the pointers and counters are.
  logic [CXU_ID_W-1:0]   mem_cxu_q   [DEPTH];
  logic [STATE_ID_W-1:0] mem_state_q [DEPTH];
  logic [FUNC_W-1:0]     mem_func_q  [DEPTH];
  logic [INSN_W-1:0]     mem_insn_q  [DEPTH];
  logic [CXU_DATA_W-1:0] mem_data0_q [DEPTH];
  logic [CXU_DATA_W-1:0] mem_data1_q [DEPTH];

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [3:0]       inflight_q, inflight_d;

  logic full, empty, at_max;
  logic push, pop, resp_hs;

  assign full   = (level_q == LVL_W'(DEPTH));
  assign empty  = (level_q == '0);
  assign at_max = (inflight_q == 4'(MAX_INFLIGHT));

  // Both valid/ready outputs come from registered state and clk_en only.
  assign req_ready   = clk_en && !full;
  assign t_req_valid = clk_en && !empty && !at_max;

  assign push    = req_valid && req_ready;
  assign pop     = t_req_valid && t_req_ready;
  assign resp_hs = t_resp_valid && resp_ready && clk_en;

  assign t_req_cxu   = mem_cxu_q[rptr_q];
  assign t_req_state = mem_state_q[rptr_q];
  assign t_req_func  = mem_func_q[rptr_q];
  assign t_req_insn  = mem_insn_q[rptr_q];
  assign t_req_data0 = mem_data0_q[rptr_q];
  assign t_req_data1 = mem_data1_q[rptr_q];

  assign resp_valid   = t_resp_valid;
  assign resp_status  = t_resp_status;
  assign resp_data    = t_resp_data;
  assign t_resp_ready = resp_ready;

  assign level    = level_q;
  assign inflight = inflight_q;

  always_comb begin
    wptr_d = push ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d = pop ? rptr_q + PTR_W'(1) : rptr_q;
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop && !push) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  // A stray response at zero holds the counter rather than wrapping.
  always_comb begin
    inflight_d = inflight_q;
    case ({pop, resp_hs})
      2'b10: inflight_d = inflight_q + 4'd1;
      2'b01: begin
        if (inflight_q != '0) begin
          inflight_d = inflight_q - 4'd1;
        end
      end
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_cxu_q[wptr_q]   <= req_cxu;
      mem_state_q[wptr_q] <= req_state;
      mem_func_q[wptr_q]  <= req_func;
      mem_insn_q[wptr_q]  <= req_insn;
      mem_data0_q[wptr_q] <= req_data0;
      mem_data1_q[wptr_q] <= req_data1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      inflight_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      inflight_q <= inflight_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && resp_hs) begin
      assert (inflight_q != '0)
        else $error("cxu_l2_req_fifo: response with no request outstanding");
    end
  end
`endif

endmodule

// File: tb/tb_cxu_l2_req_fifo.sv
// Bench for cxu_l2_req_fifo: directed scenarios then random traffic, checked against a
// queue-based model of the request buffer and a simple in-order subordinate.
module tb_cxu_l2_req_fifo;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXI  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, clk_en;
  logic        req_valid, req_ready;
  logic [0:0]  req_cxu, req_state, req_func, req_insn;
  logic [31:0] req_data0, req_data1;
  logic        resp_valid, resp_ready;
  logic [2:0]  resp_status;
  logic [31:0] resp_data;
  logic        t_req_valid, t_req_ready;
  logic [0:0]  t_req_cxu, t_req_state, t_req_func, t_req_insn;
  logic [31:0] t_req_data0, t_req_data1;
  logic        t_resp_valid, t_resp_ready;
  logic [2:0]  t_resp_status;
  logic [31:0] t_resp_data;
  logic [2:0]  level;
  logic [3:0]  inflight;

  cxu_l2_req_fifo #(
    .DEPTH        (DEPTH),
    .MAX_INFLIGHT (MAXI)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clk_en        (clk_en),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_cxu       (req_cxu),
    .req_state     (req_state),
    .req_func      (req_func),
    .req_insn      (req_insn),
    .req_data0     (req_data0),
    .req_data1     (req_data1),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_status   (resp_status),
    .resp_data     (resp_data),
    .t_req_valid   (t_req_valid),
    .t_req_ready   (t_req_ready),
    .t_req_cxu     (t_req_cxu),
    .t_req_state   (t_req_state),
    .t_req_func    (t_req_func),
    .t_req_insn    (t_req_insn),
    .t_req_data0   (t_req_data0),
    .t_req_data1   (t_req_data1),
    .t_resp_valid  (t_resp_valid),
    .t_resp_ready  (t_resp_ready),
    .t_resp_status (t_resp_status),
    .t_resp_data   (t_resp_data),
    .level         (level),
    .inflight      (inflight)
  );

  typedef struct packed {
    logic c, s, f, i;
    logic [31:0] d0, d1;
  } ent_t;

  ent_t        q[$];          // requests accepted but not yet issued
  logic [31:0] pend[$];       // responses the subordinate still owes, in order
  int          infl;
  bit          resp_en;
  int          ntests, nfail;
  logic [31:0] dut_issued[$];
  int          dut_pops;
  logic        last_resp_valid;
  logic [31:0] last_resp_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp)
      else begin
        nfail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic set_req(input logic [31:0] d0);
    req_cxu   = 1'($urandom);
    req_state = 1'($urandom);
    req_func  = 1'($urandom);
    req_insn  = 1'($urandom);
    req_data0 = d0;
    req_data1 = $urandom;
  endtask

  // One clock: present subordinate response, check outputs, advance the model.
  task automatic cycle(output bit acc);
    bit   exp_rdy, exp_tv, push, pop, rsp;
    ent_t h;
    if (resp_en && pend.size() > 0) begin
      t_resp_valid  = 1'b1;
      t_resp_data   = pend[0];
      t_resp_status = pend[0][2:0];
    end else begin
      t_resp_valid  = 1'b0;
      t_resp_data   = $urandom;
      t_resp_status = 3'($urandom);
    end
    #1;
    exp_rdy = clk_en && (q.size() < DEPTH);
    exp_tv  = clk_en && (q.size() > 0) && (infl < MAXI);
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("t_req_valid", 64'(t_req_valid), 64'(exp_tv));
    chk("level", 64'(level), 64'(q.size()));
    chk("inflight", 64'(inflight), 64'(infl));
    chk("resp_valid", 64'(resp_valid), 64'(t_resp_valid));
    chk("resp_data", 64'(resp_data), 64'(t_resp_data));
    chk("resp_status", 64'(resp_status), 64'(t_resp_status));
    chk("t_resp_ready", 64'(t_resp_ready), 64'(resp_ready));
    if (exp_tv) begin
      h = q[0];
      chk("t_req_fields", 64'({t_req_cxu, t_req_state, t_req_func, t_req_insn}),
          64'({h.c, h.s, h.f, h.i}));
      chk("t_req_data0", 64'(t_req_data0), 64'(h.d0));
      chk("t_req_data1", 64'(t_req_data1), 64'(h.d1));
    end
    last_resp_valid = resp_valid;
    last_resp_data  = resp_data;
    if (t_req_valid && t_req_ready) begin
      dut_issued.push_back(t_req_data0);
      dut_pops++;
    end
    push = exp_rdy && req_valid;
    pop  = exp_tv && t_req_ready;
    rsp  = t_resp_valid && resp_ready && clk_en;
    if (rsp) void'(pend.pop_front());
    if (pop) begin
      h = q.pop_front();
      pend.push_back(h.d0 + h.d1);
    end
    if (push) q.push_back({req_cxu, req_state, req_func, req_insn, req_data0, req_data1});
    if (pop && !rsp) infl++;
    else if (rsp && !pop && infl > 0) infl--;
    acc = push;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d0, input int budget);
    bit acc;
    int n;
    n = 0;
    req_valid = 1'b1;
    set_req(d0);
    do begin
      cycle(acc);
      n++;
    end while (!acc && n < budget);
    chk("send_accepted", 64'(acc), 64'(1));
    req_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    req_valid = 1'b0; t_req_ready = 1'b1; resp_en = 1'b1; resp_ready = 1'b1; clk_en = 1'b1;
    while ((q.size() > 0 || pend.size() > 0) && n < 50) begin
      cycle(acc);
      n++;
    end
    cycle(acc);
    chk("drain_level", 64'(level), 64'(0));
    chk("drain_inflight", 64'(inflight), 64'(0));
  endtask

  initial begin
    bit acc;
    ntests = 0; nfail = 0; infl = 0; dut_pops = 0;
    rst_n = 1'b0; clk_en = 1'b1; req_valid = 1'b0; t_req_ready = 1'b0; resp_ready = 1'b1;
    resp_en = 1'b0; t_resp_valid = 1'b0; t_resp_data = '0; t_resp_status = '0;
    set_req(32'd0);

    // Reset values
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_t_req_valid", 64'(t_req_valid), 64'(0));
    chk("rst_level", 64'(level), 64'(0));
    chk("rst_inflight", 64'(inflight), 64'(0));
    clk_en = 1'b0;
    #1;
    chk("rst_req_ready_noen", 64'(req_ready), 64'(0));
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single request, 1-cycle response of data0+data1
    t_req_ready = 1'b1; resp_en = 1'b1;
    req_valid = 1'b1;
    set_req(32'd5);
    req_data1 = 32'd7; req_cxu = 1'b0; req_func = 1'b0;
    cycle(acc);
    chk("single_push", 64'(acc), 64'(1));
    req_valid = 1'b0;
    dut_pops = 0;
    cycle(acc);
    chk("single_issue", 64'(dut_pops), 64'(1));
    cycle(acc);
    chk("single_resp_valid", 64'(last_resp_valid), 64'(1));
    chk("single_resp_data", 64'(last_resp_data), 64'(12));
    cycle(acc);
    chk("single_level", 64'(level), 64'(0));
    chk("single_inflight", 64'(inflight), 64'(0));

    // Fill to DEPTH with the subordinate stalled; the fifth request must wait
    t_req_ready = 1'b0; dut_issued.delete();
    for (int i = 1; i <= 4; i++) send(32'(i), 2);
    req_valid = 1'b1;
    set_req(32'd5);
    for (int i = 0; i < 3; i++) begin
      cycle(acc);
      chk("fifth_held", 64'(acc), 64'(0));
    end
    chk("full_level", 64'(level), 64'(4));
    t_req_ready = 1'b1;
    for (int i = 0; i < 4 && !acc; i++) cycle(acc);
    chk("fifth_accepted", 64'(acc), 64'(1));
    drain();
    chk("order_count", 64'(dut_issued.size()), 64'(5));
    for (int i = 0; i < 5 && i < dut_issued.size(); i++)
      chk("order_data0", 64'(dut_issued[i]), 64'(i + 1));

    // Inflight cap: subordinate withholds responses
    resp_en = 1'b0; dut_pops = 0;
    for (int i = 0; i < 4; i++) send(32'(20 + i), 2);
    cycle(acc);
    cycle(acc);
    chk("cap_two_pops", 64'(dut_pops), 64'(2));
    chk("cap_level", 64'(level), 64'(2));
    resp_en = 1'b1;
    cycle(acc);
    resp_en = 1'b0;
    cycle(acc);
    cycle(acc);
    chk("cap_one_more", 64'(dut_pops), 64'(3));

    // Response back-pressure leaves inflight unchanged
    t_req_ready = 1'b0; resp_en = 1'b1; resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle(acc);
    chk("bp_inflight", 64'(inflight), 64'(2));
    resp_ready = 1'b1;
    drain();

    // Continuous push/pop: pointers wrap repeatedly, order preserved
    dut_issued.delete();
    t_req_ready = 1'b1; resp_en = 1'b1;
    for (int i = 0; i < 22; i++) send(32'(100 + i), 1);
    drain();
    chk("stream_count", 64'(dut_issued.size()), 64'(22));
    for (int i = 0; i < 22 && i < dut_issued.size(); i++)
      chk("stream_data0", 64'(dut_issued[i]), 64'(100 + i));

    // clk_en low freezes everything
    resp_en = 1'b0;
    for (int i = 0; i < 4; i++) send(32'(200 + i), 2);
    clk_en = 1'b0; req_valid = 1'b1; resp_en = 1'b1; t_req_ready = 1'b1;
    set_req(32'd300);
    for (int i = 0; i < 3; i++) cycle(acc);
    chk("noen_level", 64'(level), 64'(2));
    chk("noen_inflight", 64'(inflight), 64'(2));
    clk_en = 1'b1; req_valid = 1'b0;
    drain();

    // Asynchronous reset mid-cycle with level=3, inflight=2
    resp_en = 1'b0; t_req_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(32'(400 + i), 2);
    cycle(acc);
    chk("pre_rst_level", 64'(level), 64'(3));
    chk("pre_rst_inflight", 64'(inflight), 64'(2));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_level", 64'(level), 64'(0));
    chk("arst_inflight", 64'(inflight), 64'(0));
    chk("arst_t_req_valid", 64'(t_req_valid), 64'(0));
    chk("arst_req_ready", 64'(req_ready), 64'(1));
    q.delete(); pend.delete(); infl = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      clk_en      = ($urandom_range(0, 9) != 0);
      req_valid   = ($urandom_range(0, 2) != 0);
      t_req_ready = ($urandom_range(0, 3) != 0);
      resp_en     = ($urandom_range(0, 2) != 0);
      resp_ready  = ($urandom_range(0, 3) != 0);
      set_req($urandom);
      cycle(acc);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
